// File: rtl/hft_pkg.sv
// Shared trading definitions used by the order dispatcher and the risk checker.
package hft_pkg;

   typedef enum logic {
      BUY  = 1'b0,
      SELL = 1'b1
   } trade_t;

endpackage

// File: rtl/order_dispatcher.sv
// Pre-trade risk initiator: issues a risk check per request, waits for the verdict,
// presents approved orders on valid/ready and owns the signed net position.
module order_dispatcher
   import hft_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int QTY_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_signal,
   input  logic [QTY_WIDTH-1:0]  i_req_quantity,
   input  logic [DATA_WIDTH-1:0] i_fixed_risk_limit,
   output logic                  o_risk_start,
   output logic                  o_risk_signal,
   output logic [QTY_WIDTH-1:0]  o_risk_quantity,
   output logic [DATA_WIDTH-1:0] o_risk_position,
   output logic [DATA_WIDTH-1:0] o_risk_limit,
   input  logic                  i_risk_hold,
   input  logic                  i_risk_data_valid,
   output logic                  o_order_valid,
   input  logic                  i_order_ready,
   output logic                  o_order_side,
   output logic [QTY_WIDTH-1:0]  o_order_quantity,
   output logic [DATA_WIDTH-1:0] o_position,
   output logic                  o_rejected,
   output logic                  o_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [CNT_W-1:0]      r_wait_cnt;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic                  w_accept;
   logic                  w_approve;
   logic                  w_reject;
   logic                  w_expire;
   logic                  w_handshake;
   logic [DATA_WIDTH-1:0] w_qty_ext;

   logic                  r_risk_start;
   logic                  r_risk_signal;
   logic [QTY_WIDTH-1:0]  r_risk_quantity;
   logic [DATA_WIDTH-1:0] r_risk_position;
   logic [DATA_WIDTH-1:0] r_risk_limit;
   logic                  r_order_valid;
   logic                  r_order_side;
   logic [QTY_WIDTH-1:0]  r_order_quantity;
   logic [DATA_WIDTH-1:0] r_position;
   logic                  r_rejected;
   logic                  r_timeout;

   assign w_cnt_inc = r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   assign w_qty_ext = {{(DATA_WIDTH-QTY_WIDTH){1'b0}}, r_order_quantity};

   // Next-state decode and the single-cycle events that drive the registers.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_approve    = 1'b0;
      w_reject     = 1'b0;
      w_expire     = 1'b0;
      w_handshake  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_WAIT;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_WAIT: begin
            // A verdict in the expiry cycle takes priority over the timeout.
            if (i_risk_data_valid) begin
               w_state_next = i_risk_hold ? S_IDLE : S_ISSUE;
               w_reject     = i_risk_hold;
               w_approve    = ~i_risk_hold;
            end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
               w_expire     = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_WAIT;
            end
         end
         S_ISSUE: begin
            if (i_order_ready) begin
               w_handshake  = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_ISSUE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State, latched trade data, position and output pulses.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state          <= S_IDLE;
         r_wait_cnt       <= {CNT_W{1'b0}};
         r_risk_start     <= 1'b0;
         r_risk_signal    <= 1'b0;
         r_risk_quantity  <= {QTY_WIDTH{1'b0}};
         r_risk_position  <= {DATA_WIDTH{1'b0}};
         r_risk_limit     <= {DATA_WIDTH{1'b0}};
         r_order_valid    <= 1'b0;
         r_order_side     <= 1'b0;
         r_order_quantity <= {QTY_WIDTH{1'b0}};
         r_position       <= {DATA_WIDTH{1'b0}};
         r_rejected       <= 1'b0;
         r_timeout        <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_risk_start <= w_accept;
         r_rejected   <= w_reject | w_expire;
         r_timeout    <= w_expire;
         if (w_accept) begin
            r_risk_signal   <= i_req_signal;
            r_risk_quantity <= i_req_quantity;
            r_risk_position <= r_position;
            r_risk_limit    <= i_fixed_risk_limit;
            r_wait_cnt      <= {CNT_W{1'b0}};
         end else if (r_state == S_WAIT) begin
            r_wait_cnt <= w_cnt_inc;
         end
         if (w_approve) begin
            r_order_valid    <= 1'b1;
            r_order_side     <= r_risk_signal;
            r_order_quantity <= r_risk_quantity;
         end else if (w_handshake) begin
            r_order_valid <= 1'b0;
         end
         // Position wraps modulo 2^DATA_WIDTH; the risk checker keeps it in range.
         if (w_handshake) begin
            if (r_order_side == SELL) begin
               r_position <= r_position - w_qty_ext;
            end else begin
               r_position <= r_position + w_qty_ext;
            end
         end
      end
   end

   assign o_req_ready      = (r_state == S_IDLE);
   assign o_risk_start     = r_risk_start;
   assign o_risk_signal    = r_risk_signal;
   assign o_risk_quantity  = r_risk_quantity;
   assign o_risk_position  = r_risk_position;
   assign o_risk_limit     = r_risk_limit;
   assign o_order_valid    = r_order_valid;
   assign o_order_side     = r_order_side;
   assign o_order_quantity = r_order_quantity;
   assign o_position       = r_position;
   assign o_rejected       = r_rejected;
   assign o_timeout        = r_timeout;

endmodule

// File: doc/order_dispatcher.md
# order_dispatcher

Initiator side of the pre-trade risk check. Accepts trade requests from the strategy, issues a one-cycle check request carrying side, quantity, current position and limit to the risk checker, and waits for its verdict. Approved trades are presented as orders on a valid/ready interface. The block also owns the signed net position, which is updated when an order is accepted downstream.

## Interface
- DATA_WIDTH, 32, width of position and risk limit (two's complement)
- QTY_WIDTH, 16, width of order quantity (unsigned)
- TIMEOUT_CYCLES, 8, maximum cycles to wait for a verdict before treating the trade as held

- i_clk  in  1  clock; one clock domain
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  strategy request valid
- o_req_ready  out  1  high only in IDLE
- i_req_signal  in  1  side: 0 = BUY, 1 = SELL
- i_req_quantity  in  QTY_WIDTH  request quantity
- i_fixed_risk_limit  in  DATA_WIDTH  limit, sampled at request accept
- o_risk_start  out  1  one-cycle check strobe
- o_risk_signal  out  1  latched side
- o_risk_quantity  out  QTY_WIDTH  latched quantity
- o_risk_position  out  DATA_WIDTH  position snapshot at accept
- o_risk_limit  out  DATA_WIDTH  latched limit
- i_risk_hold  in  1  verdict: 1 = reject
- i_risk_data_valid  in  1  verdict strobe
- o_order_valid  out  1  approved order pending
- i_order_ready  in  1  downstream accepts order
- o_order_side  out  1  order side
- o_order_quantity  out  QTY_WIDTH  order quantity
- o_position  out  DATA_WIDTH  current net position
- o_rejected  out  1  one-cycle pulse on hold verdict or timeout
- o_timeout  out  1  one-cycle pulse on timeout (coincides with o_rejected)

## Operation
- States: IDLE, WAIT, ISSUE.
- IDLE: o_req_ready=1. On i_req_valid, latch side, quantity, limit, and position snapshot. Register o_risk_start=1 for exactly one cycle. Clear the wait counter. Go to WAIT.
- WAIT: count cycles. If i_risk_data_valid:
  - hold=1: pulse o_rejected and go to IDLE.
  - hold=0: set o_order_valid and go to ISSUE.
- WAIT timeout: if the counter reaches TIMEOUT_CYCLES without a verdict, pulse o_rejected and o_timeout, then go to IDLE. A verdict in the same cycle as expiry wins; no timeout pulse in that case.
- ISSUE: hold o_order_valid, side and quantity stable until i_order_ready. On the handshake:
  - BUY: position += zero-extended quantity.
  - SELL: position -= zero-extended quantity.
  - Arithmetic is modulo 2^DATA_WIDTH with no saturation; the risk checker bounds the position.
  - Clear o_order_valid and go to IDLE.
- i_risk_data_valid outside WAIT is ignored. Only one trade is in flight at a time.
- o_risk_* data outputs hold their latched values until the next accept.

## Timing
- Reset values: state IDLE, o_position 0, o_order_valid 0, o_risk_start 0, o_rejected 0, o_timeout 0. All latched data outputs reset to 0. o_req_ready reflects IDLE, so it is 1 in the cycle after reset.
- Reset mid-operation (WAIT or ISSUE) aborts the trade. No order is issued and position returns to 0.
- All outputs are registered except o_req_ready, which is decoded from state.
- With a 1-cycle responder:
  - request accepted at cycle 0
  - o_risk_start high in cycle 1
  - verdict in cycle 2
  - o_order_valid high from cycle 3
  - with i_order_ready=1, position updates at the end of cycle 3 and o_req_ready is high in cycle 4
- Minimum request-to-request spacing is 4 cycles.
- Wait counter width is $clog2(TIMEOUT_CYCLES+1). The timeout fires TIMEOUT_CYCLES cycles after entering WAIT.

## Structure
- Shared package hft_pkg holds trade_t (BUY=0, SELL=1), used here and by the risk checker.
- The state enum is local to the module.
- Single flat module; no sub-module needed. The risk checker is instantiated alongside it in the bench and at top level.

## Test plan
- Reset, then BUY 100 with limit 1000 and position 0, i_order_ready=1:
  - o_risk_start pulses in cycle 1
  - o_order_valid with side 0, quantity 100 from cycle 3
  - o_position becomes 100
- Starting from position 950, BUY 100 with limit 1000: hold=1, so o_rejected pulses, no o_order_valid, and position stays 950.
- Starting from position 0, SELL 500 with limit 1000: order issued and position becomes -500 (0xFFFFFE0C).
- Verdict withheld, TIMEOUT_CYCLES=8:
  - o_rejected and o_timeout pulse 8 cycles after entering WAIT
  - a verdict arriving later is ignored
- Approved order with i_order_ready low for 5 cycles:
  - o_order_valid, side and quantity remain stable
  - o_req_ready stays 0
  - position updates only on the handshake cycle
- i_rst asserted in ISSUE with a pending BUY 200: next cycle has o_order_valid 0, o_position 0, o_req_ready 1.
